uart_wb_master: RTL

Wishbone initiator that drives the memory-mapped UART controller on behalf of a streaming client. It polls the controller's STATUS register, drains received bytes into an RX FIFO, and writes queued TX bytes to the DATA register whenever the transmitter is idle. It sits between a byte-stream consumer/producer (debug monitor, loader) and the Wishbone bus, so the UART is usable without a CPU.

---
 rtl/uart_wb_pkg.sv | 34 +++
 rtl/byte_fifo.sv | 61 ++++++
 rtl/uart_wb_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_wb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_wb_pkg
// Description : Shared types and constants for the UART Wishbone initiator:
//               FSM state encoding, UART controller register offsets, STATUS
//               bit positions and the GAP length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POLL    = 3'd1,
        ST_DECIDE  = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_GAP     = 3'd5
    } state_e;

    localparam logic [7:0] UART_REG_DATA   = 8'h00;
    localparam logic [7:0] UART_REG_STATUS = 8'h04;

    localparam int STAT_RX_READY = 0;
    localparam int STAT_TX_IDLE  = 5;

    // The GAP state never lasts less than two cycles so the controller's
    // busy flag has time to rise after a DATA write.
    function automatic int gap_cycles(input int poll_gap);
        return (poll_gap < 2) ? 2 : poll_gap;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous byte FIFO, first-word-fall-through head output.
//               Pointers carry one extra wrap bit: full when the wrap bits
//               differ and the index bits match, empty when equal.
// Ports       : clk, rst_n (sync, active low)
//               push/push_data  - write side, ignored when full
//               pop/pop_data    - read side, pop_data is the current head,
//                                 pop ignored when empty
//               full, empty     - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int C_AW = $clog2(DEPTH);

    logic [C_AW:0] r_wr_ptr;
    logic [C_AW:0] r_rd_ptr;
    logic [7:0]    r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                   (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define the contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[C_AW-1:0]] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr[C_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_wb_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_wb_master
// Description : Wishbone initiator that services a memory-mapped UART on
//               behalf of a byte-stream client. Polls STATUS, drains received
//               bytes into an RX FIFO and writes queued TX bytes to DATA when
//               the transmitter is idle.
// Ports       : clk_i, rst_ni (sync, active low)
//               wb_*            - Wishbone initiator port (registered outputs)
//               tx_valid_i/tx_ready_o/tx_data_i - TX byte stream in
//               rx_valid_o/rx_ready_i/rx_data_o - RX byte stream out
//               err_o           - sticky ACK-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int                    FIFO_DEPTH  = 16,
    parameter int                    POLL_GAP    = 4,
    parameter int                    ACK_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [7:0]            tx_data_i,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [7:0]            rx_data_o,
    output logic                  err_o
);

    localparam int                    C_GAP_CYCLES = gap_cycles(POLL_GAP);
    localparam int                    C_TO_W       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_DATA  = BASE_ADDR + ADDR_WIDTH'(UART_REG_DATA);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_STAT  = BASE_ADDR + ADDR_WIDTH'(UART_REG_STATUS);

    state_e                r_state;
    state_e                w_state_nxt;

    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [3:0]            r_sel;

    logic                  w_bus_req;
    logic                  w_we_nxt;
    logic [ADDR_WIDTH-1:0] w_adr_nxt;
    logic [DATA_WIDTH-1:0] w_dat_nxt;

    logic                  r_stat_rx;
    logic                  r_stat_tx;
    logic                  r_last_rx;
    logic                  r_err;
    logic [7:0]            r_gap_cnt;
    logic [C_TO_W-1:0]     r_to_cnt;

    logic                  w_ack;
    logic                  w_timeout;
    logic                  w_rx_ok;
    logic                  w_tx_ok;

    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [7:0]            w_tx_head;
    logic                  w_tx_pop;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic                  w_rx_push;
    logic                  w_dat_unused;

    // Acks are only meaningful while our own cycle is open.
    assign w_ack     = wb_ack_i && r_cyc;
    assign w_timeout = r_cyc && !wb_ack_i && (r_to_cnt == C_TO_W'(ACK_TIMEOUT - 1));

    assign w_rx_ok   = r_stat_rx && !w_rx_full;
    assign w_tx_ok   = r_stat_tx && !w_tx_empty;

    assign w_tx_pop  = (r_state == ST_WR_DATA) && w_ack;
    assign w_rx_push = (r_state == ST_RD_DATA) && w_ack;

    assign w_dat_unused = ^wb_dat_i[DATA_WIDTH-1:8];

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (tx_valid_i),
        .push_data (tx_data_i),
        .pop       (w_tx_pop),
        .pop_data  (w_tx_head),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (w_rx_push),
        .push_data (wb_dat_i[7:0]),
        .pop       (rx_ready_i),
        .pop_data  (rx_data_o),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    assign tx_ready_o = !w_tx_full;
    assign rx_valid_o = !w_rx_empty;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = ST_POLL;
            ST_POLL: begin
                if (w_timeout)  w_state_nxt = ST_GAP;
                else if (w_ack) w_state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                // Round-robin when both directions are ready.
                if (w_rx_ok && w_tx_ok) w_state_nxt = r_last_rx ? ST_WR_DATA : ST_RD_DATA;
                else if (w_rx_ok)       w_state_nxt = ST_RD_DATA;
                else if (w_tx_ok)       w_state_nxt = ST_WR_DATA;
                else                    w_state_nxt = ST_GAP;
            end
            ST_RD_DATA: begin
                if (w_timeout)  w_state_nxt = ST_GAP;
                else if (w_ack) w_state_nxt = ST_POLL;
            end
            ST_WR_DATA: begin
                if (w_timeout || w_ack) w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == 8'(C_GAP_CYCLES - 1)) w_state_nxt = ST_POLL;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Bus signals are computed from the upcoming state and
    // registered. The request is withheld on an ack edge so cyc/stb stay
    // low for at least one cycle, even on RD_DATA -> POLL.
    // ------------------------------------------------------------------
    always_comb begin
        w_bus_req = 1'b0;
        w_we_nxt  = 1'b0;
        w_adr_nxt = '0;
        w_dat_nxt = '0;
        case (w_state_nxt)
            ST_POLL: begin
                w_bus_req = !w_ack;
                w_adr_nxt = C_ADDR_STAT;
            end
            ST_RD_DATA: begin
                w_bus_req = !w_ack;
                w_adr_nxt = C_ADDR_DATA;
            end
            ST_WR_DATA: begin
                w_bus_req = !w_ack;
                w_we_nxt  = 1'b1;
                w_adr_nxt = C_ADDR_DATA;
                w_dat_nxt = {{(DATA_WIDTH-8){1'b0}}, w_tx_head};
            end
            default: ;
        endcase
        if (!w_bus_req) begin
            w_we_nxt  = 1'b0;
            w_adr_nxt = '0;
            w_dat_nxt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
        end else begin
            r_cyc <= w_bus_req;
            r_stb <= w_bus_req;
            r_we  <= w_we_nxt;
            r_adr <= w_adr_nxt;
            r_dat <= w_dat_nxt;
            r_sel <= w_bus_req ? 4'b0001 : 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Status latch, arbitration history, error flag and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stat_rx <= 1'b0;
            r_stat_tx <= 1'b0;
            r_last_rx <= 1'b0;
            r_err     <= 1'b0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == ST_POLL && w_ack) begin
                r_stat_rx <= wb_dat_i[STAT_RX_READY];
                r_stat_tx <= wb_dat_i[STAT_TX_IDLE];
            end
            if (w_rx_push) r_last_rx <= 1'b1;
            if (w_tx_pop)  r_last_rx <= 1'b0;
            if (w_timeout) r_err     <= 1'b1;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 8'd1 : 8'd0;
            r_to_cnt  <= (r_cyc && !w_ack) ? r_to_cnt + 1'b1 : '0;
        end
    end

    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;
    assign err_o    = r_err;

endmodule
`default_nettype wire
